// File: rtl/vtg_pkg.sv
// Shared phase encoding and per-axis timing record for the video timing generator.
package vtg_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SYNC = 3'd1,
        PH_BP   = 3'd2,
        PH_ACT  = 3'd3,
        PH_FP   = 3'd4
    } phase_e;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] bp;
        logic [15:0] act;
        logic [15:0] fp;
    } axis_cfg_t;

    // Down-counter reload value; a programmed length of 0 behaves as 1.
    function automatic logic [15:0] lenM1(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One axis of the raster: four-phase FSM driven by a down counter that moves
// only on step_i, flagging the final step of the front porch.
module timing_axis
    import vtg_pkg::*;
(
    input  logic      clock,
    input  logic      rst,
    input  logic      load_i,
    input  logic      halt_i,
    input  logic      step_i,
    input  axis_cfg_t cfg_i,
    output phase_e    phase_o,
    output logic      periodEnd_o
);

    phase_e      phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lastCnt;

    assign lastCnt     = (cnt_q == 16'd0);
    assign periodEnd_o = step_i && lastCnt && (phase_q == PH_FP);
    assign phase_o     = phase_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Halt and load override stepping; the counter holds the remaining steps of the phase.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (halt_i) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else if (load_i) begin
            phase_d = PH_SYNC;
            cnt_d   = lenM1(cfg_i.sync);
        end else if (step_i && (phase_q != PH_IDLE)) begin
            if (!lastCnt) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                case (phase_q)
                    PH_SYNC: begin phase_d = PH_BP;   cnt_d = lenM1(cfg_i.bp);   end
                    PH_BP:   begin phase_d = PH_ACT;  cnt_d = lenM1(cfg_i.act);  end
                    PH_ACT:  begin phase_d = PH_FP;   cnt_d = lenM1(cfg_i.fp);   end
                    PH_FP:   begin phase_d = PH_SYNC; cnt_d = lenM1(cfg_i.sync); end
                    default: begin phase_d = PH_IDLE; cnt_d = '0;                end
                endcase
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: horizontal and vertical axes chained
// together, with registered sync/de/position outputs lagging the state by one clock.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] hactive,
    input  logic [15:0] hfp,
    input  logic [15:0] hsw,
    input  logic [15:0] hbp,
    input  logic [15:0] vactive,
    input  logic [15:0] vfp,
    input  logic [15:0] vsw,
    input  logic [15:0] vbp,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_de,
    output logic [15:0] xpos,
    output logic [15:0] ypos,
    output logic        frame_start
);

    axis_cfg_t hCfg_q, vCfg_q, hCfgRaw, vCfgRaw, hCfgCur, vCfgCur;
    phase_e    hPhase, vPhase;
    logic      hEnd, vEnd, frameStart, frameHalt, deState, firstPix_q;

    assign hCfgRaw = '{sync: hsw, bp: hbp, act: hactive, fp: hfp};
    assign vCfgRaw = '{sync: vsw, bp: vbp, act: vactive, fp: vfp};

    // A new frame loads straight from the pins so the first sync phase already uses them.
    assign frameStart = enable && ((hPhase == PH_IDLE) || vEnd);
    assign frameHalt  = vEnd && !enable;
    assign hCfgCur    = frameStart ? hCfgRaw : hCfg_q;
    assign vCfgCur    = frameStart ? vCfgRaw : vCfg_q;
    assign deState    = (hPhase == PH_ACT) && (vPhase == PH_ACT);

    timing_axis uHAxis (
        .clock       (clock),
        .rst         (rst),
        .load_i      (frameStart),
        .halt_i      (frameHalt),
        .step_i      (1'b1),
        .cfg_i       (hCfgCur),
        .phase_o     (hPhase),
        .periodEnd_o (hEnd)
    );

    timing_axis uVAxis (
        .clock       (clock),
        .rst         (rst),
        .load_i      (frameStart),
        .halt_i      (frameHalt),
        .step_i      (hEnd),
        .cfg_i       (vCfgCur),
        .phase_o     (vPhase),
        .periodEnd_o (vEnd)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            hCfg_q <= '0;
            vCfg_q <= '0;
        end else if (frameStart) begin
            hCfg_q <= hCfgRaw;
            vCfg_q <= vCfgRaw;
        end
    end

    // Positions restart at each active run; ypos advances as each active line ends.
    always_ff @(posedge clock) begin
        if (rst) begin
            firstPix_q  <= 1'b0;
            frame_start <= 1'b0;
            out_hsync   <= ~HS_POL;
            out_vsync   <= ~VS_POL;
            out_de      <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
        end else begin
            firstPix_q  <= frameStart;
            frame_start <= firstPix_q;
            out_hsync   <= (hPhase == PH_SYNC) ? HS_POL : ~HS_POL;
            out_vsync   <= (vPhase == PH_SYNC) ? VS_POL : ~VS_POL;
            out_de      <= deState;
            if (firstPix_q) begin
                xpos <= '0;
                ypos <= '0;
            end else begin
                if (deState) begin
                    xpos <= out_de ? xpos + 16'd1 : 16'd0;
                end
                if (out_de && !deState) begin
                    ypos <= ypos + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a pixel/line position model feeds a per-cycle
// scoreboard, plus a table of timings with hand-derived periods and corner sequences.
module tb_video_timing_gen;

    localparam bit HS_POL  = 1'b1;
    localparam bit VS_POL  = 1'b0;
    localparam int HS_IDLE = HS_POL ? 0 : 1;
    localparam int VS_IDLE = VS_POL ? 0 : 1;

    logic        clock = 1'b0;
    logic        rst, enable;
    logic [15:0] hactive, hfp, hsw, hbp, vactive, vfp, vsw, vbp;
    logic        out_vsync, out_hsync, out_de, frame_start;
    logic [15:0] xpos, ypos;

    video_timing_gen #(.HS_POL(HS_POL), .VS_POL(VS_POL)) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .hactive     (hactive),
        .hfp         (hfp),
        .hsw         (hsw),
        .hbp         (hbp),
        .vactive     (vactive),
        .vfp         (vfp),
        .vsw         (vsw),
        .vbp         (vbp),
        .out_vsync   (out_vsync),
        .out_hsync   (out_hsync),
        .out_de      (out_de),
        .xpos        (xpos),
        .ypos        (ypos),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        hs, vs, de, fs;
        logic [15:0] x, y;
        logic        chkPos;
    } exp_t;

    typedef struct {
        logic [15:0] hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
        int          expLine, expFrame, expDe, expFalls;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[5];

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;

    // Reference model: raster position within the frame, not phase counters.
    bit mRun = 1'b0;
    int mPx = 0, mLn = 0;
    int mHsw, mHbp, mHact, mHfp, mVsw, mVbp, mVact, mVfp;

    int fsLog[$], deAtFs[$], fallAtFs[$], hsRiseLog[$];
    int deTotal = 0, fallTotal = 0;
    bit prevDe = 1'b0, prevHs = 1'b0;

    function automatic int eff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    function automatic exp_t idleExp(input bit chk);
        exp_t e;
        e.hs = ~HS_POL; e.vs = ~VS_POL; e.de = 1'b0; e.fs = 1'b0;
        e.x = '0; e.y = '0; e.chkPos = chk;
        return e;
    endfunction

    function automatic exp_t deriveExp();
        exp_t e;
        int   hOff, vOff;
        e = idleExp(1'b0);
        if (mRun) begin
            hOff = mHsw + mHbp;
            vOff = mVsw + mVbp;
            e.hs = (mPx < mHsw) ? HS_POL : ~HS_POL;
            e.vs = (mLn < mVsw) ? VS_POL : ~VS_POL;
            e.de = (mPx >= hOff) && (mPx < hOff + mHact) && (mLn >= vOff) && (mLn < vOff + mVact);
            e.fs = (mPx == 0) && (mLn == 0);
            if (e.de) begin
                e.x = 16'(mPx - hOff);
                e.y = 16'(mLn - vOff);
                e.chkPos = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic modelStart();
        mRun = 1'b1; mPx = 0; mLn = 0;
        mHsw = eff(hsw); mHbp = eff(hbp); mHact = eff(hactive); mHfp = eff(hfp);
        mVsw = eff(vsw); mVbp = eff(vbp); mVact = eff(vactive); mVfp = eff(vfp);
    endtask

    task automatic modelUpdate();
        if (rst) begin
            mRun = 1'b0;
        end else if (!mRun) begin
            if (enable) modelStart();
        end else if (mPx == mHsw + mHbp + mHact + mHfp - 1) begin
            mPx = 0;
            if (mLn == mVsw + mVbp + mVact + mVfp - 1) begin
                if (enable) modelStart();
                else mRun = 1'b0;
            end else begin
                mLn++;
            end
        end else begin
            mPx++;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        bit   bad;
        vecCount++;
        if (sbQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard cycle %0d: got de=%b with no expected record queued", cyc, out_de);
            return;
        end
        e = sbQ.pop_front();
        bad = (out_hsync !== e.hs) || (out_vsync !== e.vs) || (out_de !== e.de) || (frame_start !== e.fs)
              || (e.chkPos && ((xpos !== e.x) || (ypos !== e.y)));
        if (bad) begin
            missCount++;
            $display("[TB] FAIL outputs cycle %0d: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d (pos checked=%b)",
                     cyc, out_hsync, out_vsync, out_de, frame_start, xpos, ypos,
                     e.hs, e.vs, e.de, e.fs, e.x, e.y, e.chkPos);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        vecCount++;
        if (got != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic monitor();
        bit hsAct;
        hsAct = (out_hsync === HS_POL);
        if (frame_start === 1'b1) begin
            fsLog.push_back(cyc);
            deAtFs.push_back(deTotal);
            fallAtFs.push_back(fallTotal);
        end
        if (out_de === 1'b1) deTotal++;
        if (prevDe && (out_de !== 1'b1)) fallTotal++;
        if (hsAct && !prevHs) hsRiseLog.push_back(cyc);
        prevDe = (out_de === 1'b1);
        prevHs = hsAct;
    endtask

    // One clock: queue what the outputs must show after this edge, then compare.
    task automatic applyStimulus();
        exp_t e;
        e = rst ? idleExp(1'b1) : deriveExp();
        sbQ.push_back(e);
        modelUpdate();
        @(posedge clock);
        #1;
        checkOutput();
        monitor();
        cyc++;
    endtask

    task automatic clearLogs();
        fsLog.delete(); deAtFs.delete(); fallAtFs.delete(); hsRiseLog.delete();
        deTotal = 0; fallTotal = 0;
    endtask

    task automatic setCfg(input vec_t v);
        hactive = v.hact; hfp = v.hfp; hsw = v.hsw; hbp = v.hbp;
        vactive = v.vact; vfp = v.vfp; vsw = v.vsw; vbp = v.vbp;
    endtask

    task automatic resetStart(input vec_t v);
        setCfg(v);
        enable = 1'b1;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic waitFrames(input string name, input int n, input int budget);
        int k = 0;
        while ((fsLog.size() < n) && (k < budget)) begin
            applyStimulus();
            k++;
        end
        if (fsLog.size() < n) checkVal({name, " frame_start timeout"}, fsLog.size(), n);
    endtask

    function automatic int fsGap(input int k);
        return (fsLog.size() > k + 1) ? fsLog[k+1] - fsLog[k] : -1;
    endfunction

    function automatic int deInFrame(input int k);
        return (deAtFs.size() > k + 1) ? deAtFs[k+1] - deAtFs[k] : -1;
    endfunction

    function automatic int fallsInFrame(input int k);
        return (fallAtFs.size() > k + 1) ? fallAtFs[k+1] - fallAtFs[k] : -1;
    endfunction

    function automatic int hsGap();
        return (hsRiseLog.size() >= 2) ? hsRiseLog[1] - hsRiseLog[0] : -1;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        //         hact hfp hsw hbp vact vfp vsw vbp line frame de falls
        vecs[0] = '{16'd4, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1,  8, 48, 12, 3};
        vecs[1] = '{16'd4, 16'd1, 16'd0, 16'd1, 16'd3, 16'd1, 16'd1, 16'd0,  7, 42, 12, 3};
        vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  4, 16,  1, 1};
        vecs[3] = '{16'd6, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1, 10, 60, 18, 3};
        vecs[4] = '{16'd5, 16'd2, 16'd3, 16'd2, 16'd2, 16'd2, 16'd2, 16'd1, 12, 84, 10, 2};

        rst = 1'b1;
        enable = 1'b0;
        setCfg(vecs[0]);

        for (int i = 0; i < 5; i++) begin
            resetStart(vecs[i]);
            waitFrames($sformatf("vec%0d", i), 2, 300);
            checkVal($sformatf("vec%0d line period", i), hsGap(), vecs[i].expLine);
            checkVal($sformatf("vec%0d frame period", i), fsGap(0), vecs[i].expFrame);
            checkVal($sformatf("vec%0d de cycles", i), deInFrame(0), vecs[i].expDe);
            checkVal($sformatf("vec%0d de falls", i), fallsInFrame(0), vecs[i].expFalls);
        end

        // hactive 4 -> 6 mid-frame only lengthens lines from the following frame.
        resetStart(vecs[0]);
        waitFrames("hchg start", 1, 10);
        repeat (10) applyStimulus();
        hactive = 16'd6;
        waitFrames("hchg", 3, 200);
        checkVal("hchg old frame period", fsGap(0), 48);
        checkVal("hchg new frame period", fsGap(1), 60);
        checkVal("hchg new de cycles", deInFrame(1), 18);

        // Enable dropped at cycle 20: frame finishes, then stays idle.
        resetStart(vecs[0]);
        waitFrames("drop start", 1, 10);
        repeat (19) applyStimulus();
        enable = 1'b0;
        repeat (100) applyStimulus();
        checkVal("drop frame_start count", fsLog.size(), 1);
        checkVal("drop de in final frame", (deAtFs.size() > 0) ? deTotal - deAtFs[0] : -1, 12);
        checkVal("drop idle de", int'(out_de), 0);
        checkVal("drop idle hsync", int'(out_hsync), HS_IDLE);
        checkVal("drop idle vsync", int'(out_vsync), VS_IDLE);

        // Enable dropped then re-raised before frame end: no gap between frames.
        clearLogs();
        enable = 1'b1;
        waitFrames("reassert start", 1, 10);
        repeat (19) applyStimulus();
        enable = 1'b0;
        repeat (10) applyStimulus();
        enable = 1'b1;
        waitFrames("reassert", 2, 100);
        checkVal("reassert frame period", fsGap(0), 48);

        // One-cycle reset at cycle 30 while de is active.
        resetStart(vecs[0]);
        waitFrames("rst start", 1, 10);
        repeat (29) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkVal("rst de", int'(out_de), 0);
        checkVal("rst hsync", int'(out_hsync), HS_IDLE);
        checkVal("rst vsync", int'(out_vsync), VS_IDLE);
        checkVal("rst xpos", int'(xpos), 0);
        k = 0;
        while ((frame_start !== 1'b1) && (k < 10)) begin
            applyStimulus();
            k++;
        end
        checkVal("rst restart latency", k, 2);
        clearLogs();
        repeat (50) applyStimulus();
        checkVal("rst next frame_start", (fsLog.size() > 0) ? fsLog[0] - (cyc - 50) : -1, 47);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter HS_POL, default 1, meaning hsync active level (1 = active-high).
REQ-002 SHALL have parameter VS_POL, default 1, meaning vsync active level.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, run request.
REQ-006 SHALL have ports hactive, hfp, hsw, hbp, input, 16 each, pixel counts of active, front porch, sync width and back porch.
REQ-007 SHALL have ports vactive, vfp, vsw, vbp, input, 16 each, line counts of the same four vertical phases.
REQ-008 SHALL have ports out_vsync, out_hsync, out_de, output, 1 each, native timing for the downstream out port.
REQ-009 SHALL have ports xpos, ypos, output, 16 each, active pixel/line index, valid while out_de=1.
REQ-010 SHALL have port frame_start, output, 1, single-cycle pulse on the first cycle of each frame.

Function
REQ-011 SHALL run one horizontal FSM: H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC, each state lasting its programmed pixel count.
REQ-012 SHALL run one vertical FSM: V_SYNC -> V_BP -> V_ACT -> V_FP -> V_SYNC, advancing only on the last cycle of H_FP; each state lasts its programmed line count.
REQ-013 SHALL treat any programmed length of 0 as 1.
REQ-014 SHALL compute line period = hsw+hbp+hactive+hfp and frame period = (vsw+vbp+vactive+vfp) lines, with 17-bit internal sums and no wrap for 16-bit inputs.
REQ-015 SHALL drive out_hsync = HS_POL while in H_SYNC, else ~HS_POL; out_vsync = VS_POL while in V_SYNC, else ~VS_POL.
REQ-016 SHALL drive out_de = 1 only when both FSMs are in their ACT states.
REQ-017 SHALL register all outputs; they reflect the FSM state of the same cycle, one clock after the state register update.
REQ-018 SHALL increment xpos per active pixel from 0 and ypos per active line from 0; both reset to 0 at frame_start.
REQ-019 SHALL latch all eight timing inputs only at frame start; changes mid-frame take effect on the next frame.
REQ-020 SHALL, when idle and enable=1, start a frame at pixel 0 of H_SYNC/V_SYNC on the next cycle and pulse frame_start.
REQ-021 SHALL, when enable falls mid-frame, complete the current frame and then go idle; re-assertion before frame end continues without a gap.
REQ-022 SHALL, while idle, hold out_hsync=~HS_POL, out_vsync=~VS_POL, out_de=0, frame_start=0.

Reset
REQ-023 SHALL on rst=1 force both FSMs idle, counters to 0, out_de=0, frame_start=0, xpos=ypos=0, syncs at inactive level, overriding enable.
REQ-024 SHALL, on reset mid-frame, drop out_de within one cycle and restart only at a new frame start.

Structure
REQ-025 SHALL place the four-phase state encoding and idle code in a shared package vtg_pkg.
REQ-026 SHALL implement each axis with one sub-module timing_axis (phase FSM + down counter, step input, end-of-period output), instantiated twice.

Verification
REQ-027 hactive=4,hfp=1,hsw=2,hbp=1, vactive=3,vfp=1,vsw=1,vbp=1, enable=1 -> hsync period 8 cycles with 2 active, frame 48 cycles, 12 de cycles per frame, frame_start every 48 cycles.
REQ-028 Same timing -> xpos runs 0..3 and ypos 0..2 during de; downstream out port sees three de falling edges per frame.
REQ-029 Change hactive 4->6 mid-frame -> current frame keeps 8-cycle lines; next frame 10-cycle lines, 18 de cycles.
REQ-030 hsw=0, vbp=0 -> behaves as 1; line period = 1+hbp+hactive+hfp.
REQ-031 Deassert enable at cycle 20 of a frame -> frame completes at cycle 48, outputs idle afterward, no frame_start.
REQ-032 Assert rst at cycle 30 for 1 cycle -> out_de=0 next cycle, syncs inactive; with enable high, new frame_start the cycle after rst releases.
